// File: rtl/mand_frame_scheduler.sv
// Multi-channel Mandelbrot frame scheduler. It scans a frame, hands pixels to external
// solvers, colour-maps the returned iteration counts and streams one byte per pixel to SRAM.
module mand_frame_scheduler #(
  parameter int                 H_RES       = 640,
  parameter int                 V_RES       = 480,
  parameter int                 NUM_SOLVERS = 4,
  parameter int                 COORD_W     = 27,
  parameter int                 ITER_W      = 32,
  parameter int                 ZOOM_SHIFT  = 6,
  parameter logic [COORD_W-1:0] INIT_STEP   = COORD_W'(4096),
  parameter logic [31:0]        BASE_ADDR   = 32'h0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             run,
  input  logic                             zoom_en,
  input  logic [COORD_W-1:0]               center_re,
  input  logic [COORD_W-1:0]               center_im,
  output logic [NUM_SOLVERS-1:0]           solver_start,
  output logic [NUM_SOLVERS*COORD_W-1:0]   solver_c_re,
  output logic [NUM_SOLVERS*COORD_W-1:0]   solver_c_im,
  input  logic [NUM_SOLVERS-1:0]           solver_done,
  input  logic [NUM_SOLVERS*ITER_W-1:0]    solver_iter,
  output logic                             sram_write,
  input  logic                             sram_ready,
  output logic [31:0]                      sram_address,
  output logic [7:0]                       sram_writedata,
  output logic                             frame_done,
  output logic                             busy,
  output logic [COORD_W-1:0]               step,
  output logic [15:0]                      frame_count
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int NW = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  localparam logic [XW-1:0]      X_LAST   = XW'(H_RES - 1);
  localparam logic [YW-1:0]      Y_LAST   = YW'(V_RES - 1);
  localparam logic [COORD_W-1:0] HALF_W   = COORD_W'(H_RES / 2);
  localparam logic [COORD_W-1:0] HALF_H   = COORD_W'(V_RES / 2);
  localparam logic [COORD_W-1:0] STEP_MIN = COORD_W'(1);
  localparam logic [NW:0]        N_CH     = (NW+1)'(NUM_SOLVERS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_DISPATCH = 3'd2,
    S_DRAIN    = 3'd3,
    S_ZOOM     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_BUSY   = 2'd1,
    CH_RESULT = 2'd2
  } ch_e;

  state_e                        state_q, state_d;
  logic [XW-1:0]                 x_q, x_d;
  logic [YW-1:0]                 y_q, y_d;
  logic [COORD_W-1:0]            cur_re_q, cur_re_d;
  logic [COORD_W-1:0]            cur_im_q, cur_im_d;
  logic [COORD_W-1:0]            row_re0_q, row_re0_d;
  logic [COORD_W-1:0]            step_q, step_d;
  logic [15:0]                   frame_count_q, frame_count_d;
  logic                          frame_done_q, frame_done_d;
  logic                          busy_q, busy_d;
  logic [NUM_SOLVERS-1:0]        start_q, start_d;
  logic [NUM_SOLVERS*COORD_W-1:0] c_re_q, c_re_d;
  logic [NUM_SOLVERS*COORD_W-1:0] c_im_q, c_im_d;
  ch_e                           ch_state_q [NUM_SOLVERS];
  ch_e                           ch_state_d [NUM_SOLVERS];
  logic [ITER_W-1:0]             ch_iter_q  [NUM_SOLVERS];
  logic [ITER_W-1:0]             ch_iter_d  [NUM_SOLVERS];
  logic [XW-1:0]                 ch_x_q     [NUM_SOLVERS];
  logic [XW-1:0]                 ch_x_d     [NUM_SOLVERS];
  logic [YW-1:0]                 ch_y_q     [NUM_SOLVERS];
  logic [YW-1:0]                 ch_y_d     [NUM_SOLVERS];
  logic                          wr_valid_q, wr_valid_d;
  logic [NW-1:0]                 wr_ch_q, wr_ch_d;
  logic [31:0]                   wr_addr_q, wr_addr_d;
  logic [7:0]                    wr_data_q, wr_data_d;
  logic [NW-1:0]                 last_gnt_q, last_gnt_d;

  logic                          dispatch_hit_s;
  logic [NW-1:0]                 dispatch_idx_s;
  logic                          all_idle_s;
  logic                          gnt_hit_s;
  logic [NW-1:0]                 gnt_idx_s;
  logic [NW:0]                   cand_sum_s;
  logic [NW:0]                   cand_s;
  logic                          accept_s;
  logic [COORD_W-1:0]            zoom_step_s;

  // all-ones means the point never escaped; otherwise the colour grows with log2(iter)
  function automatic logic [7:0] colour_map(input logic [ITER_W-1:0] iter);
    logic [2:0] k;
    logic [7:0] c;
    k = 3'd0;
    if (&iter) begin
      c = 8'hFF;
    end else if (iter <= ITER_W'(1)) begin
      c = 8'h00;
    end else begin
      for (int b = 1; b < ITER_W; b++) begin
        k = iter[b] ? ((b >= 7) ? 3'd7 : 3'(b)) : k;
      end
      c = {3'b000, k, 2'b00};
    end
    return c;
  endfunction

  // Channel search: lowest free channel for dispatch, round-robin result for the SRAM port
  always_comb begin
    dispatch_hit_s = 1'b0;
    dispatch_idx_s = '0;
    all_idle_s     = 1'b1;
    gnt_hit_s      = 1'b0;
    gnt_idx_s      = '0;
    cand_sum_s     = '0;
    cand_s         = '0;
    for (int i = NUM_SOLVERS - 1; i >= 0; i--) begin
      if (ch_state_q[i] == CH_IDLE) begin
        dispatch_hit_s = 1'b1;
        dispatch_idx_s = NW'(i);
      end else begin
        all_idle_s = 1'b0;
      end
    end
    for (int off = 1; off <= NUM_SOLVERS; off++) begin
      cand_sum_s = {1'b0, last_gnt_q} + (NW+1)'(off);
      cand_s     = (cand_sum_s >= N_CH) ? (cand_sum_s - N_CH) : cand_sum_s;
      // the channel already presenting on the bus stays RESULT until accepted; skip it
      if (!gnt_hit_s && (ch_state_q[cand_s[NW-1:0]] == CH_RESULT) &&
          !(wr_valid_q && (wr_ch_q == cand_s[NW-1:0]))) begin
        gnt_hit_s = 1'b1;
        gnt_idx_s = cand_s[NW-1:0];
      end else begin
        gnt_hit_s = gnt_hit_s;
      end
    end
  end

  // Next-state logic for the frame FSM, channels and write port
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    cur_re_d      = cur_re_q;
    cur_im_d      = cur_im_q;
    row_re0_d     = row_re0_q;
    step_d        = step_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    start_d       = '0;
    c_re_d        = c_re_q;
    c_im_d        = c_im_q;
    ch_state_d    = ch_state_q;
    ch_iter_d     = ch_iter_q;
    ch_x_d        = ch_x_q;
    ch_y_d        = ch_y_q;
    wr_valid_d    = wr_valid_q;
    wr_ch_d       = wr_ch_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    last_gnt_d    = last_gnt_q;
    accept_s      = wr_valid_q && sram_ready;
    zoom_step_s   = step_q - COORD_W'($signed(step_q) >>> ZOOM_SHIFT);

    for (int i = 0; i < NUM_SOLVERS; i++) begin
      case (ch_state_q[i])
        CH_BUSY: begin
          if (solver_done[i]) begin
            ch_state_d[i] = CH_RESULT;
            ch_iter_d[i]  = solver_iter[i*ITER_W +: ITER_W];
          end else begin
            ch_state_d[i] = CH_BUSY;
          end
        end
        CH_RESULT: begin
          if (accept_s && (wr_ch_q == NW'(i))) begin
            ch_state_d[i] = CH_IDLE;
          end else begin
            ch_state_d[i] = CH_RESULT;
          end
        end
        CH_IDLE: ch_state_d[i] = CH_IDLE;
        default: ch_state_d[i] = CH_IDLE;
      endcase
    end

    if (gnt_hit_s && (!wr_valid_q || sram_ready)) begin
      wr_valid_d = 1'b1;
      wr_ch_d    = gnt_idx_s;
      last_gnt_d = gnt_idx_s;
      wr_addr_d  = BASE_ADDR + (32'(ch_y_q[gnt_idx_s]) * 32'(H_RES)) + 32'(ch_x_q[gnt_idx_s]);
      wr_data_d  = colour_map(ch_iter_q[gnt_idx_s]);
    end else if (accept_s) begin
      wr_valid_d = 1'b0;
    end else begin
      wr_valid_d = wr_valid_q;
    end

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        row_re0_d = center_re - HALF_W * step_q;
        cur_re_d  = center_re - HALF_W * step_q;
        cur_im_d  = center_im - HALF_H * step_q;
        x_d       = '0;
        y_d       = '0;
        state_d   = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (dispatch_hit_s) begin
          start_d[dispatch_idx_s]                      = 1'b1;
          c_re_d[dispatch_idx_s*COORD_W +: COORD_W]    = cur_re_q;
          c_im_d[dispatch_idx_s*COORD_W +: COORD_W]    = cur_im_q;
          ch_state_d[dispatch_idx_s]                   = CH_BUSY;
          ch_x_d[dispatch_idx_s]                       = x_q;
          ch_y_d[dispatch_idx_s]                       = y_q;
          // incremental stepping: no per-pixel multiply
          if (x_q == X_LAST) begin
            x_d      = '0;
            cur_re_d = row_re0_q;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = S_DRAIN;
            end else begin
              y_d      = y_q + YW'(1);
              cur_im_d = cur_im_q + step_q;
            end
          end else begin
            x_d      = x_q + XW'(1);
            cur_re_d = cur_re_q + step_q;
          end
        end else begin
          state_d = S_DISPATCH;
        end
      end
      S_DRAIN: begin
        if (all_idle_s && !wr_valid_q) begin
          state_d       = S_ZOOM;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          if (zoom_en) begin
            step_d = ($signed(zoom_step_s) < $signed(STEP_MIN)) ? STEP_MIN : zoom_step_s;
          end else begin
            step_d = step_q;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_ZOOM: begin
        if (run) begin
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State register; reset has priority over everything
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      cur_re_q      <= '0;
      cur_im_q      <= '0;
      row_re0_q     <= '0;
      step_q        <= INIT_STEP;
      frame_count_q <= 16'd0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      start_q       <= '0;
      c_re_q        <= '0;
      c_im_q        <= '0;
      wr_valid_q    <= 1'b0;
      wr_ch_q       <= '0;
      wr_addr_q     <= 32'h0;
      wr_data_q     <= 8'h00;
      last_gnt_q    <= NW'(NUM_SOLVERS - 1);
      for (int i = 0; i < NUM_SOLVERS; i++) begin
        ch_state_q[i] <= CH_IDLE;
        ch_iter_q[i]  <= '0;
        ch_x_q[i]     <= '0;
        ch_y_q[i]     <= '0;
      end
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      cur_re_q      <= cur_re_d;
      cur_im_q      <= cur_im_d;
      row_re0_q     <= row_re0_d;
      step_q        <= step_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
      start_q       <= start_d;
      c_re_q        <= c_re_d;
      c_im_q        <= c_im_d;
      wr_valid_q    <= wr_valid_d;
      wr_ch_q       <= wr_ch_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      last_gnt_q    <= last_gnt_d;
      for (int i = 0; i < NUM_SOLVERS; i++) begin
        ch_state_q[i] <= ch_state_d[i];
        ch_iter_q[i]  <= ch_iter_d[i];
        ch_x_q[i]     <= ch_x_d[i];
        ch_y_q[i]     <= ch_y_d[i];
      end
    end
  end

  assign solver_start   = start_q;
  assign solver_c_re    = c_re_q;
  assign solver_c_im    = c_im_q;
  assign sram_write     = wr_valid_q;
  assign sram_address   = wr_addr_q;
  assign sram_writedata = wr_data_q;
  assign frame_done     = frame_done_q;
  assign busy           = busy_q;
  assign step           = step_q;
  assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_mand_frame_scheduler.sv
// Directed bench for mand_frame_scheduler on a 4x2 frame with four solver channels,
// a behavioural solver model and an SRAM scoreboard.
module tb_mand_frame_scheduler;

  localparam int H = 4;
  localparam int V = 2;
  localparam int N = 4;
  localparam int CW = 27;
  localparam int IW = 32;
  localparam int NPIX = H * V;

  logic            clk = 1'b0;
  logic            reset;
  logic            run;
  logic            zoom_en;
  logic [CW-1:0]   center_re;
  logic [CW-1:0]   center_im;
  logic [N-1:0]    solver_start;
  logic [N*CW-1:0] solver_c_re;
  logic [N*CW-1:0] solver_c_im;
  logic [N-1:0]    solver_done = '0;
  logic [N*IW-1:0] solver_iter = '0;
  logic            sram_write;
  logic            sram_ready = 1'b1;
  logic [31:0]     sram_address;
  logic [7:0]      sram_writedata;
  logic            frame_done;
  logic            busy;
  logic [CW-1:0]   step;
  logic [15:0]     frame_count;

  mand_frame_scheduler #(
    .H_RES(H), .V_RES(V), .NUM_SOLVERS(N), .COORD_W(CW), .ITER_W(IW),
    .ZOOM_SHIFT(6), .INIT_STEP(27'd4096), .BASE_ADDR(32'h0)
  ) dut (
    .clock(clk), .reset(reset), .run(run), .zoom_en(zoom_en),
    .center_re(center_re), .center_im(center_im),
    .solver_start(solver_start), .solver_c_re(solver_c_re), .solver_c_im(solver_c_im),
    .solver_done(solver_done), .solver_iter(solver_iter),
    .sram_write(sram_write), .sram_ready(sram_ready),
    .sram_address(sram_address), .sram_writedata(sram_writedata),
    .frame_done(frame_done), .busy(busy), .step(step), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // pixel k of the frame gets iter_tab[k]; colour_tab holds the hand-derived bytes
  logic [31:0] iter_tab   [NPIX] = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd64, 32'd200, 32'd5};
  logic [7:0]  colour_tab [NPIX] = '{8'hFF, 8'h00, 8'h00, 8'h04, 8'h04, 8'h18, 8'h1C, 8'h08};

  int          cre = 0;
  int          cim = 0;
  int          cur_step = 4096;
  int          exp_fc = 0;
  int          lat_lo = 3;
  int          lat_hi = 3;
  bit          rand_ready = 1'b0;
  bit          in_order = 1'b1;
  int          k = 0;
  int          fd_seen = 0;
  int          writes_total = 0;
  int          wr_idx = 0;
  int          cnt [N] = '{0, 0, 0, 0};
  int          pix [N] = '{0, 0, 0, 0};
  int          wcnt [NPIX];
  logic [7:0]  wdata [NPIX];
  logic        pend = 1'b0;
  logic [31:0] pend_addr;
  logic [7:0]  pend_data;
  logic [CW-1:0] first_c_re = '0;
  logic [CW-1:0] first_c_im = '0;

  assign center_re = CW'(cre);
  assign center_im = CW'(cim);

  // solver model, SRAM responder and scoreboard, all stepped #1 after each rising edge
  initial begin
    logic [N-1:0]    done_v;
    logic [N*IW-1:0] iter_v;
    logic [CW-1:0]   e_re;
    logic [CW-1:0]   e_im;
    logic            rdy;
    for (int a = 0; a < NPIX; a++) begin
      wcnt[a] = 0;
      wdata[a] = 8'h00;
    end
    forever begin
      @(posedge clk);
      #1;
      done_v = '0;
      iter_v = solver_iter;
      for (int i = 0; i < N; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            done_v[i] = 1'b1;
            iter_v[i*IW +: IW] = iter_tab[pix[i]];
          end
        end
      end
      if (reset) begin
        k = 0;
        wr_idx = 0;
        pend = 1'b0;
        cur_step = 4096;
        exp_fc = 0;
        rdy = 1'b1;
        for (int a = 0; a < NPIX; a++) wcnt[a] = 0;
      end else begin
        if (frame_done) begin
          fd_seen++;
          exp_fc++;
          if (zoom_en) begin
            cur_step = cur_step - (cur_step >>> 6);
            if (cur_step < 1) cur_step = 1;
          end
          check_eq("frame_count", frame_count, exp_fc);
          check_eq("step", step, CW'(cur_step));
          check_eq("dispatch_count", k, NPIX);
          for (int a = 0; a < NPIX; a++) begin
            check_eq("write_once", wcnt[a], 1);
            check_eq("write_data", wdata[a], colour_tab[a]);
            wcnt[a] = 0;
          end
          k = 0;
          wr_idx = 0;
        end
        for (int i = 0; i < N; i++) begin
          if (solver_start[i]) begin
            e_re = CW'(cre - (H / 2) * cur_step + (k % H) * cur_step);
            e_im = CW'(cim - (V / 2) * cur_step + ((k / H) % V) * cur_step);
            check_eq("c_re", solver_c_re[i*CW +: CW], e_re);
            check_eq("c_im", solver_c_im[i*CW +: CW], e_im);
            if (k == 0) begin
              first_c_re = solver_c_re[i*CW +: CW];
              first_c_im = solver_c_im[i*CW +: CW];
            end
            pix[i] = k % NPIX;
            k++;
            cnt[i] = $urandom_range(lat_lo, lat_hi);
          end
        end
        if (pend) begin
          check_eq("hold_write", sram_write, 1'b1);
          check_eq("hold_addr", sram_address, pend_addr);
          check_eq("hold_data", sram_writedata, pend_data);
        end
        rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        pend = sram_write && !rdy;
        pend_addr = sram_address;
        pend_data = sram_writedata;
        if (sram_write && rdy) begin
          writes_total++;
          if (sram_address < 32'(NPIX)) begin
            wcnt[sram_address]++;
            wdata[sram_address] = sram_writedata;
          end else begin
            check_eq("write_addr_range", sram_address, 32'(NPIX - 1));
          end
          if (in_order) check_eq("write_order", sram_address, wr_idx);
          wr_idx++;
        end
      end
      sram_ready = rdy;
      solver_done = done_v;
      solver_iter = iter_v;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_start"}, solver_start, '0);
    check_eq({tag, "_c_re"}, solver_c_re, '0);
    check_eq({tag, "_c_im"}, solver_c_im, '0);
    check_eq({tag, "_write"}, sram_write, 1'b0);
    check_eq({tag, "_addr"}, sram_address, 32'h0);
    check_eq({tag, "_data"}, sram_writedata, 8'h00);
    check_eq({tag, "_frame_done"}, frame_done, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_step"}, step, 27'd4096);
    check_eq({tag, "_frame_count"}, frame_count, 16'd0);
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n = 0;
    while (fd_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, fd_seen, target);
  endtask

  initial begin
    int n;
    int w0;
    reset = 1'b1;
    run = 1'b0;
    zoom_en = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // one frame, fixed latency, SRAM always ready, run dropped right after start
    @(negedge clk);
    run = 1'b1;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("a_busy_rise", busy, 1'b1);
    run = 1'b0;
    wait_frames(1, 500, "a_frame_done");
    repeat (2) @(negedge clk);
    check_eq("a_busy_fall", busy, 1'b0);
    check_eq("a_frame_count", frame_count, 16'd1);
    check_eq("a_step_no_zoom", step, 27'd4096);
    check_eq("a_first_c_re", first_c_re, 27'h7FF_E000);
    check_eq("a_first_c_im", first_c_im, 27'h7FF_F000);
    check_eq("a_writes", writes_total, 8);

    // three zoomed frames, random latencies and SRAM back-pressure, offset centre
    in_order = 1'b0;
    rand_ready = 1'b1;
    lat_lo = 1;
    lat_hi = 20;
    zoom_en = 1'b1;
    cre = 1000;
    cim = -2000;
    run = 1'b1;
    wait_frames(2, 3000, "b_frame1");
    check_eq("b_step1", step, 27'd4032);
    wait_frames(3, 3000, "b_frame2");
    check_eq("b_step2", step, 27'd3969);
    repeat (3) @(negedge clk);
    run = 1'b0;
    wait_frames(4, 3000, "b_frame3");
    check_eq("b_step3", step, 27'd3907);
    repeat (2) @(negedge clk);
    check_eq("b_busy_fall", busy, 1'b0);
    check_eq("b_frame_count", frame_count, 16'd4);
    check_eq("b_writes", writes_total, 32);

    // reset mid-frame; solver results still in flight must be dropped
    rand_ready = 1'b0;
    lat_lo = 10;
    lat_hi = 20;
    zoom_en = 1'b0;
    run = 1'b1;
    n = 0;
    while (k < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("r_dispatched", k, 3);
    reset = 1'b1;
    run = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    w0 = writes_total;
    repeat (40) @(negedge clk);
    check_eq("r_late_done_ignored", writes_total, w0);
    check_eq("r_busy", busy, 1'b0);
    check_eq("r_write", sram_write, 1'b0);
    check_eq("r_frame_count", frame_count, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mand_frame_scheduler.md
Name: mand_frame_scheduler

Overview:
Parametrised successor to the single-solver pixel walker. It scans an H_RES x V_RES frame and dispatches per-pixel complex coordinates to NUM_SOLVERS external Mandelbrot solvers, one pixel per free solver. It colour-maps the returned iteration counts and writes one byte per pixel to VGA SRAM over a valid/ready handshake. Zoom is applied per frame, and run/stop is under host control.

Parameters:
H_RES, 640, pixels per line
V_RES, 480, lines per frame
NUM_SOLVERS, 4, solver channels (1..16)
COORD_W, 27, signed fixed-point coordinate width
ITER_W, 32, solver iteration-count width
ZOOM_SHIFT, 6, per-frame zoom: step -= step>>>ZOOM_SHIFT
INIT_STEP, 27'd4096, pixel pitch loaded at reset
BASE_ADDR, 32'h0, SRAM address of pixel (0,0)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
run  in  1  start/continue frames
zoom_en  in  1  apply zoom at end of frame
center_re  in  COORD_W  frame centre, real; sampled at frame start
center_im  in  COORD_W  frame centre, imag; sampled at frame start
solver_start  out  NUM_SOLVERS  one-cycle start pulse per channel
solver_c_re  out  NUM_SOLVERS*COORD_W  flattened; channel i at [i*COORD_W +: COORD_W]
solver_c_im  out  NUM_SOLVERS*COORD_W  same layout
solver_done  in  NUM_SOLVERS  one-cycle result-valid pulse per channel
solver_iter  in  NUM_SOLVERS*ITER_W  iteration count; all-ones = never escaped
sram_write  out  1  write valid
sram_ready  in  1  SRAM accepts write
sram_address  out  32  BASE_ADDR + y*H_RES + x
sram_writedata  out  8  RGB332 colour
frame_done  out  1  one-cycle pulse per completed frame
busy  out  1  high outside S_IDLE
step  out  COORD_W  current pixel pitch
frame_count  out  16  completed frames; wraps at 65535

Behaviour:
- Reset values: all outputs 0, except step = INIT_STEP. All channels go to IDLE, state goes to S_IDLE, and x/y counters are cleared. Reset wins over every other event.
- Top FSM:
  - S_IDLE: go to S_SETUP when run=1.
  - S_SETUP, one cycle: latch centres; row_re0 = center_re - (H_RES/2)*step; cur_im = center_im - (V_RES/2)*step. Products are truncated to COORD_W.
  - S_DISPATCH: after the last pixel (x=H_RES-1, y=V_RES-1) is dispatched, go to S_DRAIN.
  - S_DRAIN: wait until every channel is IDLE and no write is pending. Then go to S_ZOOM.
  - S_ZOOM, one cycle: pulse frame_done; frame_count += 1; if zoom_en, step <= step - (step>>>ZOOM_SHIFT), clamped to a minimum of 1. Next state is S_SETUP if run=1, else S_IDLE.
- Deasserting run mid-frame finishes the current frame; the block stops only at S_ZOOM.
- Coordinate generation uses no per-pixel multiply: cur_re += step for each x; at end of line, cur_re = row_re0 and cur_im += step.
- Scan order: x from 0 to H_RES-1, then y from 0 to V_RES-1. The counters never reach H_RES or V_RES.
- Per-channel state: IDLE -> BUSY -> RESULT -> IDLE.
  - Dispatch: in S_DISPATCH, the lowest-index IDLE channel gets the current pixel. solver_start[i]=1 for one cycle, with c_re/c_im valid that cycle and held until the next start. The pixel x,y is tagged in the channel. At most one dispatch per cycle.
  - solver_done[i] while BUSY: capture the iteration count and go to RESULT. solver_done on an IDLE or RESULT channel is ignored.
- Write arbitration: round-robin over RESULT channels, starting after the last granted channel; one write per cycle.
  - sram_write is asserted the cycle after the grant. Address and data stay stable until sram_write && sram_ready.
  - On acceptance the channel returns to IDLE. A new grant may present on the next cycle (back-to-back writes allowed).
- Colour map:
  - iter all-ones -> 8'hFF.
  - Otherwise, iter <= 1 -> 8'h00.
  - Otherwise, k = min(msb_index(iter), 7) and colour = {3'b000, k[2:0], 2'b00}. Examples: 2 -> 8'h04, 128 and above -> 8'h1C.
- Latency: minimum of 2 cycles from solver_done to sram_write.
- Simultaneous events: done and start on the same channel cannot coincide, because a channel is IDLE only after its write is accepted. A dispatch and a write acceptance in the same cycle are independent.

Test Plan:
- NUM_SOLVERS=1, H_RES=4, V_RES=2, solver model returns iter=5 after 3 cycles; run=1 -> addresses 0..7 in order, data 8'h08 each, one frame_done, frame_count=1.
- NUM_SOLVERS=4, random solver latencies 1-20 -> every address 0..H_RES*V_RES-1 written exactly once per frame; no write lost while sram_ready toggles randomly.
- iter values all-ones, 0, 1, 2, 3, 64, 200 -> data FF, 00, 00, 04, 04, 18, 1C.
- INIT_STEP=4096, ZOOM_SHIFT=6, zoom_en=1, three frames -> step 4096, 4032, 3969, 3907; with zoom_en=0, step stays 4096.
- run dropped mid-frame -> frame completes, frame_done pulses, busy falls; reset asserted mid-frame -> next cycle all outputs at reset values and late solver_done pulses are ignored.
- Centre (0,0), step=4096, H_RES=640 -> first dispatched c_re = -1310720, c_im = -983040.
